// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: seed, tap masks and the checker state encoding,
// so the PRBS generator and checker agree on one polynomial.
package lfsr_pkg;

    localparam int unsigned LFSR_W  = 8;
    localparam logic [7:0]  INIT    = 8'b1000_0000;
    localparam logic [7:0]  FIB_TAP = 8'b0010_1101;
    localparam logic [7:0]  GAL_TAP = 8'b1011_0100;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at one so that event is not lost.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic [W-1:0] count_r;

    // Count register: clear has priority but keeps a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO;
        end else if (clr) begin
            count_r <= inc ? ONE : ZERO;
        end else if (inc && (count_r != ALL1)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci LFSR stream, declares
// lock, then counts bit errors against a free-running local copy.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAP       = WIDTH'(FIB_TAP),
    parameter int unsigned      LOCK_GOOD = 16,
    parameter int unsigned      WINDOW    = 64,
    parameter int unsigned      ERR_LIMIT = 4,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             lock_lost
);

    localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW);
    localparam int unsigned FILL_W = $clog2(WIDTH + 1);
    localparam int unsigned WERR_W = $clog2(ERR_LIMIT + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = {{(GOOD_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE   = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
    localparam logic [WERR_W-1:0] WERR_LIM  = WERR_W'(ERR_LIMIT);
    localparam logic [WERR_W-1:0] WERR_ONE  = {{(WERR_W-1){1'b0}}, 1'b1};

    function automatic logic tap_parity(input logic [WIDTH-1:0] v);
        return ^(v & TAP);
    endfunction

    prbs_chk_state_t   state_r, state_next_s;
    logic [WIDTH-1:0]  hist_r, hist_next_s;
    logic [FILL_W-1:0] fill_r, fill_next_s;
    logic [GOOD_W-1:0] good_r, good_next_s;
    logic [WIN_W-1:0]  win_r, win_next_s;
    logic [WERR_W-1:0] werr_r, werr_next_s, werr_plus_s;
    logic              pred_s, mis_s, lost_s;
    logic              locked_r, err_pulse_r, lock_lost_r;

    assign pred_s = tap_parity(hist_r);

    // Next-state, history and window bookkeeping; nothing moves without in_valid.
    always_comb begin
        state_next_s = state_r;
        hist_next_s  = hist_r;
        fill_next_s  = fill_r;
        good_next_s  = good_r;
        win_next_s   = win_r;
        werr_next_s  = werr_r;
        mis_s        = 1'b0;
        lost_s       = 1'b0;
        werr_plus_s  = werr_r + WERR_ONE;
        if (in_valid) begin
            case (state_r)
                FILL: begin
                    hist_next_s = {in_bit, hist_r[WIDTH-1:1]};
                    if (fill_r == FILL_LAST) begin
                        fill_next_s = {FILL_W{1'b0}};
                        good_next_s = {GOOD_W{1'b0}};
                        // An all-zero seed would lock onto the degenerate sequence.
                        if (hist_next_s != {WIDTH{1'b0}}) begin
                            state_next_s = VERIFY;
                        end else begin
                            state_next_s = FILL;
                        end
                    end else begin
                        fill_next_s = fill_r + FILL_ONE;
                    end
                end
                VERIFY: begin
                    hist_next_s = {in_bit, hist_r[WIDTH-1:1]};
                    if (in_bit == pred_s) begin
                        if (good_r == GOOD_LAST) begin
                            state_next_s = LOCKED;
                            good_next_s  = {GOOD_W{1'b0}};
                            win_next_s   = {WIN_W{1'b0}};
                            werr_next_s  = {WERR_W{1'b0}};
                        end else begin
                            good_next_s = good_r + GOOD_ONE;
                        end
                    end else begin
                        state_next_s = FILL;
                        fill_next_s  = {FILL_W{1'b0}};
                        good_next_s  = {GOOD_W{1'b0}};
                    end
                end
                LOCKED: begin
                    // Self-generate so a line error never enters the history.
                    hist_next_s = {pred_s, hist_r[WIDTH-1:1]};
                    mis_s       = (in_bit != pred_s);
                    if (mis_s && (werr_plus_s == WERR_LIM)) begin
                        lost_s       = 1'b1;
                        state_next_s = FILL;
                        fill_next_s  = {FILL_W{1'b0}};
                        win_next_s   = {WIN_W{1'b0}};
                        werr_next_s  = {WERR_W{1'b0}};
                    end else if (win_r == WIN_LAST) begin
                        win_next_s  = {WIN_W{1'b0}};
                        werr_next_s = {WERR_W{1'b0}};
                    end else begin
                        win_next_s  = win_r + WIN_ONE;
                        werr_next_s = mis_s ? werr_plus_s : werr_r;
                    end
                end
                default: begin
                    state_next_s = FILL;
                    fill_next_s  = {FILL_W{1'b0}};
                    good_next_s  = {GOOD_W{1'b0}};
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, history, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FILL;
            hist_r      <= {WIDTH{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            good_r      <= {GOOD_W{1'b0}};
            win_r       <= {WIN_W{1'b0}};
            werr_r      <= {WERR_W{1'b0}};
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            hist_r      <= hist_next_s;
            fill_r      <= fill_next_s;
            good_r      <= good_next_s;
            win_r       <= win_next_s;
            werr_r      <= werr_next_s;
            locked_r    <= (state_next_s == LOCKED);
            err_pulse_r <= mis_s;
            lock_lost_r <= lost_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mis_s),
        .clr   (err_clr),
        .count (err_count)
    );

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign lock_lost = lock_lost_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed vector table, hand-written corner sequences
// and a randomized soak, all compared against a bit-level reference model.
module tb_prbs_checker;
    import lfsr_pkg::*;

    localparam int GEN_LEN  = 16384;
    localparam int M_FILL   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked, err_pulse, lock_lost;
    logic [15:0] err_count;
    logic        locked4, err_pulse4, lock_lost4;
    logic [3:0]  err_count4;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .lock_lost(lock_lost)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .err_clr(err_clr),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .lock_lost(lock_lost4)
    );

    typedef struct {
        bit v; bit b; bit clr; bit r;
        bit e_locked; bit e_pulse; bit e_lost; int e_cnt;
    } vec_t;
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;
    bit gen [GEN_LEN];
    int gi = 0;

    int m_mode, m_nfill, m_ngood, m_wpos, m_werr, m_cnt16, m_cnt4;
    bit m_ep, m_ll;
    bit m_hist[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_FILL; m_nfill = 0; m_ngood = 0; m_wpos = 0; m_werr = 0;
        m_cnt16 = 0; m_cnt4 = 0; m_ep = 1'b0; m_ll = 1'b0;
        m_hist = {};
        for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
    endtask

    // Reference: history as a bit queue (index 0 oldest); the tap mask
    // 0010_1101 means next = x[n] ^ x[n+2] ^ x[n+3] ^ x[n+5].
    task automatic model_step(bit v, bit b, bit clr);
        bit inc = 1'b0;
        bit pred;
        int ones;
        m_ep = 1'b0;
        m_ll = 1'b0;
        if (v) begin
            pred = m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[5];
            if (m_mode == M_FILL) begin
                m_hist.push_back(b); void'(m_hist.pop_front());
                m_nfill++;
                if (m_nfill == 8) begin
                    m_nfill = 0;
                    ones = 0;
                    foreach (m_hist[i]) ones += int'(m_hist[i]);
                    if (ones != 0) begin m_mode = M_VERIFY; m_ngood = 0; end
                end
            end else if (m_mode == M_VERIFY) begin
                m_hist.push_back(b); void'(m_hist.pop_front());
                if (b == pred) begin
                    m_ngood++;
                    if (m_ngood == 16) begin m_mode = M_LOCKED; m_wpos = 0; m_werr = 0; end
                end else begin
                    m_mode = M_FILL; m_nfill = 0; m_ngood = 0;
                end
            end else begin
                m_hist.push_back(pred); void'(m_hist.pop_front());
                if (b != pred) begin inc = 1'b1; m_ep = 1'b1; m_werr++; end
                if (m_werr == 4) begin
                    m_mode = M_FILL; m_nfill = 0; m_ll = 1'b1;
                end else if (m_wpos == 63) begin
                    m_wpos = 0; m_werr = 0;
                end else begin
                    m_wpos++;
                end
            end
        end
        if (clr) begin
            m_cnt16 = int'(inc); m_cnt4 = int'(inc);
        end else if (inc) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
    endtask

    task automatic step(bit v, bit b, bit clr, bit r);
        in_valid = v; in_bit = b; err_clr = clr; rst = r;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_step(v, b, clr);
        check("locked",     locked,     int'(m_mode == M_LOCKED));
        check("err_pulse",  err_pulse,  int'(m_ep));
        check("lock_lost",  lock_lost,  int'(m_ll));
        check("err_count",  err_count,  m_cnt16);
        check("locked4",    locked4,    int'(m_mode == M_LOCKED));
        check("err_pulse4", err_pulse4, int'(m_ep));
        check("lock_lost4", lock_lost4, int'(m_ll));
        check("err_count4", err_count4, m_cnt4);
    endtask

    task automatic send(bit flip);
        step(1'b1, gen[gi] ^ flip, 1'b0, 1'b0);
        gi = (gi + 1) % GEN_LEN;
    endtask

    task automatic relock(string tag);
        for (int i = 0; i < 24; i++) begin
            if (i == 23) check({tag, "_prelock"}, locked, 0);
            send(1'b0);
        end
        check({tag, "_lock"}, locked, 1);
    endtask

    initial begin
        int npulse;
        int nv;
        bit v, f, c, r;

        for (int i = 0; i < 8; i++) gen[i] = INIT[i];
        for (int n = 0; n + 8 < GEN_LEN; n++)
            gen[n+8] = gen[n] ^ gen[n+2] ^ gen[n+3] ^ gen[n+5];

        // Directed table: reset, first lock with an idle mid-fill, one flip, clear.
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        for (int i = 0; i < 24; i++) begin
            if (i == 3) tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
            tbl.push_back('{1'b1, gen[gi], 1'b0, 1'b0, (i == 23), 1'b0, 1'b0, 0});
            gi++;
        end
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, ~gen[gi], 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1}); gi++;
        tbl.push_back('{1'b1, gen[gi], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1}); gi++;
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        tbl.push_back('{1'b1, gen[gi], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0}); gi++;

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].b, tbl[k].clr, tbl[k].r);
            check($sformatf("vec%0d_locked", k), locked, int'(tbl[k].e_locked));
            check($sformatf("vec%0d_pulse", k), err_pulse, int'(tbl[k].e_pulse));
            check($sformatf("vec%0d_lost", k), lock_lost, int'(tbl[k].e_lost));
            check($sformatf("vec%0d_cnt", k), err_count, tbl[k].e_cnt);
            check($sformatf("vec%0d_cnt4", k), err_count4, tbl[k].e_cnt);
        end

        // Long clean run after lock: no errors, lock held.
        npulse = 0;
        for (int i = 0; i < 1000; i++) begin
            send(1'b0);
            npulse += int'(err_pulse);
        end
        check("clean_pulses", npulse, 0);
        check("clean_cnt", err_count, 0);
        check("clean_locked", locked, 1);

        // Reset while locked.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_lost", lock_lost, 0);
        check("rst_cnt", err_count, 0);
        relock("rst");

        // Four errors inside one window lose lock on the fourth.
        for (int p = 0; p < 16; p++) send(p % 5 == 0);
        check("loss4_lost", lock_lost, 1);
        check("loss4_locked", locked, 0);
        check("loss4_cnt", err_count, 4);
        send(1'b0);
        check("loss4_lost_clear", lock_lost, 0);
        for (int i = 0; i < 23; i++) send(1'b0);
        check("loss4_relock", locked, 1);

        // Three errors per window, last one on the wrap bit: never loses lock.
        for (int w = 0; w < 6; w++)
            for (int p = 0; p < 64; p++) send(p == 2 || p == 30 || p == 63);
        check("three_locked", locked, 1);
        check("three_cnt", err_count, 22);
        check("three_cnt4_sat", err_count4, 15);

        // Fourth error on the wrap bit: loss of lock wins over window clear.
        for (int p = 0; p < 64; p++) send(p >= 60);
        check("wrap_lost", lock_lost, 1);
        check("wrap_locked", locked, 0);
        check("wrap_cnt4_sat", err_count4, 15);
        relock("wrap");

        // Clear coincident with an error.
        step(1'b1, ~gen[gi], 1'b1, 1'b0); gi++;
        check("clrinc_cnt", err_count, 1);
        check("clrinc_cnt4", err_count4, 1);
        check("clrinc_pulse", err_pulse, 1);

        // All-zero stream never leaves fill.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_locked", locked, 0);
        check("zero_cnt", err_count, 0);

        // Random 50% valid on a clean stream: lock after 24 valid bits.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        nv = 0;
        for (int it = 0; it < 2000 && nv < 24; it++) begin
            v = 1'($urandom_range(0, 1));
            if (v && nv == 23) check("rv_prelock", locked, 0);
            step(v, gen[gi], 1'b0, 1'b0);
            if (v) begin gi++; nv++; end
        end
        check("rv_lock", locked, 1);

        // Randomized soak with errors, clears, idles and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 999) == 0);
            step(v, gen[gi] ^ f, c, r);
            if (v) gi = (gi + 1) % GEN_LEN;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
